arm_wr_arbiter: RTL and testbench
=================================

Name: arm_wr_arbiter

Overview:
- Shares the single write port of instruction_ram between two requesters.
  - Translator emit path: appends ARM words sequentially.
  - Branch-patch path: overwrites an already-emitted word at a given address.
- Owns the append pointer and sequences the instruction_ram start/ready handshake.
- Returns a per-requester ack and flags protocol errors.
- Sits between the translator state machine and instruction_ram.

Parameters:
- ADDRESS_WIDTH, 10, width of ARM instruction RAM word address.
- RAM_SIZE, 1024, number of words in instruction_ram; append limit.
- TIMEOUT, 255, max cycles to wait for ram_ready before aborting a write.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- emit_req  in  1  translator requests append of emit_word; held until emit_ack.
- emit_word  in  32  ARM word to append.
- emit_ack  out  1  one-cycle pulse: append completed or rejected.
- patch_req  in  1  patch unit requests overwrite; held until patch_ack.
- patch_addr  in  ADDRESS_WIDTH  target word address.
- patch_word  in  32  replacement ARM word.
- patch_ack  out  1  one-cycle pulse: patch completed or rejected.
- req_err  out  1  valid with either ack; 1 = rejected (full, bad address, timeout).
- ram_start  out  1  one-cycle start pulse to instruction_ram.
- ram_ready  in  1  instruction_ram write complete.
- ram_addr  out  ADDRESS_WIDTH  write address, stable from ram_start until ready.
- ram_word  out  32  write data, stable from ram_start until ready.
- emit_ptr  out  ADDRESS_WIDTH+1  number of words appended so far (next append address).
- full  out  1  emit_ptr == RAM_SIZE.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; emit_ptr=0; last_grant=PATCH (so emit wins first tie); timeout counter=0. All outputs 0: acks, req_err, ram_start, ram_addr, ram_word, full, busy.
- Reset mid-transfer aborts at once. No ack is produced for the aborted request. Requesters must re-issue.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Sample requests and grant one. If both are pending, grant the one not in last_grant (round-robin).
  - Validity checks on grant:
    - Emit with full=1: go to ACK with req_err=1; no RAM access.
    - Patch with patch_addr >= emit_ptr: go to ACK with req_err=1 (cannot patch unwritten words).
  - Otherwise latch address/word: emit uses emit_ptr; patch uses patch_addr. Go to ISSUE.
  - last_grant updates on every grant, including rejected ones.
- ISSUE: ram_start=1 for exactly this cycle; ram_addr/ram_word driven from latch. Go to WAIT; clear timeout counter.
- WAIT:
  - ram_start=0.
  - ram_ready=1: go to ACK, req_err=0; if grant was emit, emit_ptr += 1 in the same cycle.
  - Counter reaches TIMEOUT without ready: go to ACK, req_err=1, emit_ptr unchanged.
  - ram_ready seen in the ISSUE cycle is ignored; only WAIT samples it.
- ACK: pulse the granted requester's ack for one cycle with req_err, then go to IDLE. A requester drops req on the cycle after ack. The earliest re-grant is the cycle after ACK.
- Latency, accepted write: request sampled in IDLE (cycle 0) -> ram_start cycle 1 -> ready at earliest cycle 2 -> ack cycle 3. Minimum 4 cycles per write.
- Rejected request: ack 1 cycle after grant.
- emit_ptr never wraps; it saturates at RAM_SIZE and full stays 1 until reset.
- Requests arriving in non-IDLE states wait; no request is lost while req is held.
- A patch to the address currently being appended cannot occur (address must be < emit_ptr).

Decomposition:
- Shared package holds:
  - State encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3).
  - Grant encoding (EMIT=0, PATCH=1).
  - ARM word width constant 32.
  - ARM_PUSH_WORD constant 32'hE52D0004, shared with the translator.
- One sub-module is natural: rr_arb2, a 2-input round-robin arbiter with last_grant register and update enable.

Test Plan:
- Single emit, emit_word=32'hE3A00005, ram_ready asserted 2 cycles after start -> ram_addr=0, one ram_start pulse, emit_ack with req_err=0, emit_ptr=1.
- Both requesters held from reset release: emit 32'h1, patch addr 0 word 32'h2 -> grants in order emit then patch. Patch rejected (emit_ptr was 0 at its grant? no: emit first makes ptr=1) so patch writes addr 0, data 32'h2, req_err=0.
- Patch with patch_addr=5 when emit_ptr=3 -> patch_ack with req_err=1 one cycle after grant; ram_start never asserted.
- RAM_SIZE=4 override, five emits -> first four write addrs 0..3, full=1. Fifth gets emit_ack with req_err=1 and no ram_start.
- TIMEOUT=8, ram_ready held 0 -> ack with req_err=1 exactly 8 WAIT cycles after ram_start; emit_ptr unchanged.
- reset driven low in WAIT -> next cycle all outputs 0, emit_ptr=0, no ack. A late ram_ready after reset is ignored in IDLE.

Source files
------------

// File: rtl/arm_wr_arbiter_pkg.sv
// Shared types and constants for the instruction RAM write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_wr_arbiter_pkg;

    localparam int          ARM_WORD_W    = 32;
    // Canonical "push {r0}" encoding, also used by the translator.
    localparam logic [31:0] ARM_PUSH_WORD = 32'hE52D0004;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_EMIT  = 1'b0,
        GNT_PATCH = 1'b1
    } grant_t;

endpackage

// File: rtl/arm_wr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
// Latency: grant is combinational; last_grant updates on the clock when update is high.
// Backpressure: none; the caller decides when a grant is taken via update.
// Ports: req_emit/req_patch requests, update commits the current grant,
//        grant/grant_vld the winner and whether any request is pending.
module arm_wr_arbiter_rr_arb2
    import arm_wr_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_emit,
    input  logic   req_patch,
    input  logic   update,
    output grant_t grant,
    output logic   grant_vld
);

    grant_t last_grant;

    always_comb begin
        grant_vld = req_emit | req_patch;
        if (req_emit && req_patch)
            grant = (last_grant == GNT_PATCH) ? GNT_EMIT : GNT_PATCH;
        else if (req_emit)
            grant = GNT_EMIT;
        else
            grant = GNT_PATCH;
    end

    // Starts as PATCH so that emit wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset)
            last_grant <= GNT_PATCH;
        else if (update && grant_vld)
            last_grant <= grant;
    end

endmodule

// File: rtl/arm_wr_arbiter.sv
// Shares the instruction_ram write port between the translator append path and the branch-patch path.
// Latency: accepted write = grant, start, >=1 wait, ack (>=4 cycles); rejected request acks 1 cycle after grant.
// Backpressure: requesters hold req until their one-cycle ack; requests seen outside IDLE simply wait.
// Ports: emit_req/emit_word/emit_ack append path; patch_req/patch_addr/patch_word/patch_ack patch path;
//        req_err qualifies either ack; ram_start/ram_ready/ram_addr/ram_word RAM handshake;
//        emit_ptr/full/busy status.
module arm_wr_arbiter
    import arm_wr_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int RAM_SIZE      = 1024,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     emit_req,
    input  logic [ARM_WORD_W-1:0]    emit_word,
    output logic                     emit_ack,
    input  logic                     patch_req,
    input  logic [ADDRESS_WIDTH-1:0] patch_addr,
    input  logic [ARM_WORD_W-1:0]    patch_word,
    output logic                     patch_ack,
    output logic                     req_err,
    output logic                     ram_start,
    input  logic                     ram_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [ARM_WORD_W-1:0]    ram_word,
    output logic [ADDRESS_WIDTH:0]   emit_ptr,
    output logic                     full,
    output logic                     busy
);

    localparam int                 CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDRESS_WIDTH:0] PTR_MAX = (ADDRESS_WIDTH + 1)'(RAM_SIZE);

    state_t             state, state_nxt;
    grant_t             gnt, grant_q;
    logic               gnt_vld;
    logic               gnt_reject;
    logic               err_q;
    logic               timeout_hit;
    logic [CNT_W-1:0]   wait_cnt;

    arm_wr_arbiter_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_emit  (emit_req),
        .req_patch (patch_req),
        .update    (state == ST_IDLE),
        .grant     (gnt),
        .grant_vld (gnt_vld)
    );

    assign full = (emit_ptr == PTR_MAX);

    // Appends are refused once full; patches may only touch words already emitted.
    assign gnt_reject  = (gnt == GNT_EMIT) ? full : ({1'b0, patch_addr} >= emit_ptr);
    assign timeout_hit = (wait_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (gnt_vld) state_nxt = gnt_reject ? ST_ACK : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (ram_ready || timeout_hit) state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: grant/error latch, write latch, append pointer, wait counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_q  <= GNT_EMIT;
            err_q    <= 1'b0;
            ram_addr <= '0;
            ram_word <= '0;
            emit_ptr <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        grant_q <= gnt;
                        err_q   <= gnt_reject;
                        if (!gnt_reject) begin
                            ram_addr <= (gnt == GNT_EMIT) ? emit_ptr[ADDRESS_WIDTH-1:0] : patch_addr;
                            ram_word <= (gnt == GNT_EMIT) ? emit_word : patch_word;
                        end
                    end
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    if (ram_ready) begin
                        err_q <= 1'b0;
                        // The full check is belt-and-braces: a full append never reaches WAIT.
                        if (grant_q == GNT_EMIT && !full)
                            emit_ptr <= emit_ptr + 1'b1;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        ram_start = (state == ST_ISSUE);
        emit_ack  = (state == ST_ACK) && (grant_q == GNT_EMIT);
        patch_ack = (state == ST_ACK) && (grant_q == GNT_PATCH);
        req_err   = (state == ST_ACK) && err_q;
        busy      = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_arm_wr_arbiter.sv
// Self-checking bench for arm_wr_arbiter: directed steps followed by randomized rounds.
// Latency: n/a.
// Backpressure: bench acts as instruction_ram, answering ram_start with a chosen ready delay.
module tb_arm_wr_arbiter;
    import arm_wr_arbiter_pkg::*;

    localparam int AW    = 10;
    localparam int RS    = 4;
    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          emit_req, patch_req, ram_ready;
    logic [31:0]   emit_word, patch_word;
    logic [AW-1:0] patch_addr;
    logic          emit_ack, patch_ack, req_err, ram_start, full, busy;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_word;
    logic [AW:0]   emit_ptr;

    always #5 clk = ~clk;

    arm_wr_arbiter #(.ADDRESS_WIDTH(AW), .RAM_SIZE(RS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .emit_req(emit_req), .emit_word(emit_word), .emit_ack(emit_ack),
        .patch_req(patch_req), .patch_addr(patch_addr), .patch_word(patch_word), .patch_ack(patch_ack),
        .req_err(req_err), .ram_start(ram_start), .ram_ready(ram_ready),
        .ram_addr(ram_addr), .ram_word(ram_word),
        .emit_ptr(emit_ptr), .full(full), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    // Reference model: words appended so far and who won the last grant (1 = patch).
    int mptr   = 0;
    bit mlast  = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {emit_ack, patch_ack, req_err, ram_start, full, busy}, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_word"}, ram_word, 0);
        chk({tag, "_ptr"}, emit_ptr, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0; emit_req = 1'b0; patch_req = 1'b0; ram_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        mptr  = 0;
        mlast = 1'b1;
    endtask

    // Raise the selected requests while the DUT is idle, serve RAM writes with
    // the given ready delays (cycles after ram_start), and check every ack.
    task automatic round(input bit de, input bit dp, input logic [31:0] ew,
                         input logic [AW-1:0] pa, input logic [31:0] pw,
                         input int d_e, input int d_p);
        bit first, who, rej, err, started, got;
        int n, g, d, exp_ack, ready_at;
        logic [AW-1:0] xa;
        logic [31:0]   xw;
        emit_req = de; emit_word = ew;
        patch_req = dp; patch_addr = pa; patch_word = pw;
        n     = int'(de) + int'(dp);
        first = (de && dp) ? !mlast : !de;
        g     = cyc;
        for (int k = 0; k < n; k++) begin
            who     = (k == 0) ? first : !first;
            rej     = who ? (int'(pa) >= mptr) : (mptr == RS);
            d       = who ? d_p : d_e;
            err     = rej || (d > TO);
            xa      = who ? pa : mptr[AW-1:0];
            xw      = who ? pw : ew;
            exp_ack = rej ? g + 1 : g + 2 + ((d > TO) ? TO : d);
            started = 1'b0; got = 1'b0; ready_at = -1;
            for (int b = 0; b < 40 && !got; b++) begin
                tick();
                ram_ready = (cyc == ready_at);
                if (ram_start) begin
                    chk("start_when", (!rej && !started && cyc == g + 1), 1);
                    chk("ram_addr", ram_addr, xa);
                    chk("ram_word", ram_word, xw);
                    started  = 1'b1;
                    ready_at = cyc + d;
                end
                if (emit_ack || patch_ack) begin
                    chk("ack_who", {emit_ack, patch_ack}, who ? 2'b01 : 2'b10);
                    chk("ack_cycle", cyc, exp_ack);
                    chk("req_err", req_err, err);
                    if (!who && !err) mptr++;
                    chk("emit_ptr", emit_ptr, mptr);
                    chk("full", full, mptr == RS);
                    chk("busy", busy, 1);
                    if (who) patch_req = 1'b0; else emit_req = 1'b0;
                    got = 1'b1;
                end
            end
            chk("ack_seen", got, 1);
            chk("start_seen", started, !rej);
            ram_ready = 1'b0;
            mlast = who;
            g     = cyc + 1;
        end
        tick();
    endtask

    function automatic int rnd_delay();
        if ($urandom_range(0, 5) == 0) return NEVER;
        return $urandom_range(1, TO + 2);
    endfunction

    initial begin
        int sel;
        reset = 1'b0; emit_req = 1'b0; patch_req = 1'b0; ram_ready = 1'b0;
        emit_word = '0; patch_word = '0; patch_addr = '0;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b1;

        // Single append, ready two cycles after start.
        round(1, 0, 32'hE3A00005, '0, '0, 2, 0);

        // Both held from reset release: emit wins, then patch of address 0.
        do_reset();
        round(1, 1, 32'h1, 10'd0, 32'h2, 1, 3);
        round(1, 0, ARM_PUSH_WORD, '0, '0, 1, 0);
        round(1, 0, 32'h0000_000A, '0, '0, 4, 0);
        // emit_ptr is 3: patch beyond and at the pointer are both refused.
        round(0, 1, '0, 10'd5, 32'hBAD0_BAD0, 0, 1);
        round(0, 1, '0, 10'd3, 32'hBAD0_BAD1, 0, 1);
        // Ready on the last allowed wait cycle still succeeds; RAM becomes full.
        round(1, 0, 32'h0000_000B, '0, '0, TO, 0);
        round(1, 0, 32'h0000_000C, '0, '0, 1, 0);
        round(0, 1, '0, 10'd3, 32'hCAFE_F00D, 0, 5);
        round(1, 1, 32'h0000_000D, 10'd0, 32'h1234_5678, 1, 2);

        // Timeouts leave the pointer untouched.
        do_reset();
        round(1, 0, 32'h0000_00E1, '0, '0, NEVER, 0);
        round(1, 0, 32'h0000_00E2, '0, '0, TO + 1, 0);

        // Reset during WAIT aborts with no ack; a late ready is ignored.
        emit_req = 1'b1; emit_word = 32'h0000_00F1;
        for (int b = 0; b < 10 && !ram_start; b++) tick();
        chk("rw_start", ram_start, 1);
        tick();
        reset = 1'b0;
        tick();
        chk_zero("rst_wait");
        reset = 1'b1; emit_req = 1'b0; mptr = 0; mlast = 1'b1;
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("late_ready", {emit_ack, patch_ack, ram_start, busy}, 0);
            chk("late_ptr", emit_ptr, 0);
            tick();
        end

        // Randomized rounds against the reference model.
        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            sel = $urandom_range(1, 3);
            round(sel[0], sel[1], $urandom, AW'($urandom_range(0, 5)), $urandom,
                  rnd_delay(), rnd_delay());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
